// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state encodings
// plus the default datapath sizing.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } mdop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIN  = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_sign_adjust.sv
// Conditional two's-complement: result = negate ? -value : value.
// Serves both operand magnitude extraction and final result sign correction.
module mdu_sign_adjust #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; one bit per cycle on magnitudes,
// with sign correction applied in a single finishing cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MDop,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               is_mul;
    logic               neg_hi, neg_lo;
    logic               done_nxt, dbz_nxt;

    logic               is_div_op, sign_a, sign_b, div_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign is_div_op = MDop[1];
    assign sign_a    = MDop[0] & SrcA[WIDTH-1];
    assign sign_b    = MDop[0] & SrcB[WIDTH-1];
    assign div_zero  = is_div_op && (SrcB == '0);
    assign Busy      = (state != S_IDLE);

    mdu_sign_adjust #(.W(WIDTH)) u_abs_a (.value(SrcA), .negate(sign_a), .result(abs_a));
    mdu_sign_adjust #(.W(WIDTH)) u_abs_b (.value(SrcB), .negate(sign_b), .result(abs_b));

    // The first iteration runs on the Start edge straight from the operand
    // magnitudes, so WIDTH iterations plus FIN fit in WIDTH+1 edges.
    logic               step_mul;
    logic [2*WIDTH-1:0] step_in, step_next;
    logic [WIDTH-1:0]   step_op;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;

    always_comb begin
        if (state == S_IDLE) begin
            step_mul = ~is_div_op;
            step_op  = is_div_op ? abs_b : abs_a;
            step_in  = is_div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        end else begin
            step_mul = is_mul;
            step_op  = operand;
            step_in  = acc;
        end
    end

    // Shift-add: add multiplicand to the upper half when the multiplier LSB is set.
    assign mul_sum  = {1'b0, step_in[2*WIDTH-1:WIDTH]}
                    + (step_in[0] ? {1'b0, step_op} : {(WIDTH+1){1'b0}});
    // Restoring division: trial-subtract the divisor from the shifted partial remainder;
    // a set MSB in the difference means the divisor did not fit.
    assign div_part = step_in[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_part - {1'b0, step_op};

    always_comb begin
        if (step_mul) begin
            step_next = {mul_sum, step_in[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_next = {div_diff[WIDTH-1:0], step_in[WIDTH-2:0], 1'b1};
        end else begin
            step_next = {div_part[WIDTH-1:0], step_in[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res, fin_hi, fin_lo;

    mdu_sign_adjust #(.W(2*WIDTH)) u_prod (.value(acc), .negate(neg_lo), .result(prod_res));
    mdu_sign_adjust #(.W(WIDTH)) u_quo (.value(acc[WIDTH-1:0]), .negate(neg_lo), .result(quo_res));
    mdu_sign_adjust #(.W(WIDTH)) u_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_hi), .result(rem_res));

    assign fin_hi = is_mul ? prod_res[2*WIDTH-1:WIDTH] : rem_res;
    assign fin_lo = is_mul ? prod_res[WIDTH-1:0]       : quo_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so that no
        // path leaves a variable unassigned, which would otherwise infer a latch.
        state_nxt = state;
        done_nxt  = 1'b0;
        dbz_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    // Divide by zero resolves on the Start edge itself; no iterations run.
                    if (div_zero) begin
                        done_nxt = 1'b1;
                        dbz_nxt  = 1'b1;
                    end else begin
                        state_nxt = is_div_op ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_W'(WIDTH - 2)) state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            operand   <= '0;
            is_mul    <= 1'b0;
            neg_hi    <= 1'b0;
            neg_lo    <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            Done      <= done_nxt;
            DivByZero <= dbz_nxt;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        cnt <= '0;
                        if (div_zero) begin
                            Hi <= SrcA;
                            Lo <= '1;
                        end else begin
                            acc     <= step_next;
                            operand <= step_op;
                            is_mul  <= ~is_div_op;
                            neg_lo  <= sign_a ^ sign_b;
                            neg_hi  <= is_div_op ? sign_a : (sign_a ^ sign_b);
                        end
                    end else begin
                        if (HiWrite) Hi <= SrcA;
                        if (LoWrite) Lo <= SrcA;
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= step_next;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIN: begin
                    Hi <= fin_hi;
                    Lo <= fin_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  MDop;
    logic [31:0] SrcA, SrcB;
    logic        HiWrite, LoWrite;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk(clk), .reset(reset), .Start(Start), .MDop(MDop), .SrcA(SrcA), .SrcB(SrcB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .Busy(Busy), .Done(Done),
        .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: whole-number arithmetic, 64-bit signed where the op is signed.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p  = '0;
        case (op)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = sa * sb;
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    p  = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    p = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit now, output int edges, output logic [31:0] hi,
                          output logic [31:0] lo, output logic dz);
        if (!now) @(negedge clk);
        MDop  = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        edges = 1;
        while (Done !== 1'b1 && edges < 80) begin
            @(posedge clk); #1;
            edges++;
        end
        hi = Hi;
        lo = Lo;
        dz = DivByZero;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[$];
        int          edges;
        logic [31:0] hi, lo, a, b;
        logic        dz, mdz;
        logic [1:0]  op;
        logic [63:0] exp;

        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back('{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{2'b00, 32'd0,         32'd12345,     32'd0,         32'd0,         1'b0});
        vecs.push_back('{2'b10, 32'd5,         32'd7,         32'd5,         32'd0,         1'b0});
        vecs.push_back('{2'b01, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0});

        reset = 1'b1; Start = 1'b0; MDop = 2'b00; SrcA = '0; SrcB = '0;
        HiWrite = 1'b0; LoWrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {Busy, Done, DivByZero, Hi, Lo}, '0);
        @(negedge clk); reset = 1'b0;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, edges, hi, lo, dz);
            check($sformatf("vec%0d_latency", i), 64'(edges), vecs[i].dz ? 64'd1 : 64'd33);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d_dbz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
            check($sformatf("vec%0d_busy_at_done", i), {63'd0, Busy}, 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", i), {62'd0, Done, DivByZero}, 64'd0);
        end

        // MTHI/MTLO in IDLE, alone and together
        @(negedge clk); SrcA = 32'h1234_5678; HiWrite = 1'b1;
        @(negedge clk); SrcA = 32'h9ABC_DEF0; HiWrite = 1'b0; LoWrite = 1'b1;
        @(negedge clk); LoWrite = 1'b0;
        check("mthi_mtlo", {Hi, Lo}, {32'h1234_5678, 32'h9ABC_DEF0});
        @(negedge clk); SrcA = 32'h0BAD_F00D; HiWrite = 1'b1; LoWrite = 1'b1;
        @(negedge clk); HiWrite = 1'b0; LoWrite = 1'b0;
        check("mthi_mtlo_both", {Hi, Lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});

        // Start beats simultaneous writes; Hi/Lo hold old values while busy
        @(negedge clk); MDop = 2'b00; SrcA = 32'd2; SrcB = 32'd3;
        Start = 1'b1; HiWrite = 1'b1; LoWrite = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        check("start_beats_write", {Hi, Lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});
        check("busy_after_start", {63'd0, Busy}, 64'd1);
        // Start, MTHI and MTLO while busy are ignored
        repeat (3) @(posedge clk);
        #1; MDop = 2'b10; SrcA = 32'hDEAD_BEEF; SrcB = 32'd0;
        Start = 1'b1; HiWrite = 1'b1; LoWrite = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        check("write_ignored_busy", {Hi, Lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});
        edges = 5;
        while (Done !== 1'b1 && edges < 80) begin @(posedge clk); #1; edges++; end
        check("busy_seq_latency", 64'(edges), 64'd33);
        check("busy_seq_result", {Hi, Lo, 31'd0, DivByZero}, {32'd0, 32'd6, 32'd0});

        // Back-to-back: second Start issued in the Done cycle
        run_op(2'b00, 32'd1000, 32'd1000, 1'b0, edges, hi, lo, dz);
        check("b2b_first", {hi, lo}, {32'd0, 32'd1_000_000});
        run_op(2'b11, 32'hFFFF_FF9C, 32'd7, 1'b1, edges, hi, lo, dz);
        check("b2b_latency", 64'(edges), 64'd33);
        check("b2b_second", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        // Asynchronous reset at iteration 10 discards the operation
        @(negedge clk); MDop = 2'b00; SrcA = 32'd12; SrcB = 32'd13; Start = 1'b1;
        @(posedge clk); #1; Start = 1'b0;
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        check("async_reset", {Busy, Hi, Lo}, '0);
        @(negedge clk); reset = 1'b0;
        edges = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (Done === 1'b1) edges++;
        end
        check("no_done_after_reset", 64'(edges), 64'd0);
        run_op(2'b00, 32'd6, 32'd7, 1'b0, edges, hi, lo, dz);
        check("post_reset_mul", {hi, lo}, {32'd0, 32'd42});

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            exp = ref_model(op, a, b, mdz);
            run_op(op, a, b, 1'b0, edges, hi, lo, dz);
            check($sformatf("rnd%0d_op%0d_%h_%h", n, op, a, b), {hi, lo}, exp);
            check($sformatf("rnd%0d_dbz", n), {63'd0, dz}, {63'd0, mdz});
            check($sformatf("rnd%0d_latency", n), 64'(edges), mdz ? 64'd1 : 64'd33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
